// File: rtl/umni_aquisicao_if.sv
// umni_aquisicao_if
// Bundles the sensor inputs and the acquisition results of umni_aquisicao.
//   master : drives sensor1..sensor4, observes the results (environment / bench)
//   slave  : the acquisition block itself
// Signals:
//   sensor1..sensor4       raw humidity readings, 7-bit unsigned
//   umidade_atual_media    mean of the valid sensors of the last accepted sample
//   umidade_atual_temporal mean of the last up-to-4 accepted sample means
//   media_valida           one-cycle pulse when umidade_atual_temporal updates
//   sensores_ok            per-sensor validity at the last sample event (bit0 = sensor1)
//   janela_cheia           window holds 4 entries
//   falha_sensor           block is in the FALHA state
//   estado                 current FSM state (debug visibility)
// Handshake: media_valida is a valid-only strobe with no ready; the consumer
// must take umidade_atual_temporal in the single cycle media_valida is high.
interface umni_aquisicao_if;
    logic [6:0] sensor1;
    logic [6:0] sensor2;
    logic [6:0] sensor3;
    logic [6:0] sensor4;
    logic [6:0] umidade_atual_media;
    logic [6:0] umidade_atual_temporal;
    logic       media_valida;
    logic [3:0] sensores_ok;
    logic       janela_cheia;
    logic       falha_sensor;
    logic [1:0] estado;

    modport master (
        output sensor1, sensor2, sensor3, sensor4,
        input  umidade_atual_media, umidade_atual_temporal, media_valida,
        input  sensores_ok, janela_cheia, falha_sensor, estado
    );

    modport slave (
        input  sensor1, sensor2, sensor3, sensor4,
        output umidade_atual_media, umidade_atual_temporal, media_valida,
        output sensores_ok, janela_cheia, falha_sensor, estado
    );
endinterface

// File: rtl/umni_aquisicao.sv
// umni_aquisicao
// Humidity acquisition front end. Every DIV_AMOSTRA clocks the four sensors
// are registered and screened against LIMITE_MAX; the mean of the valid ones
// is pushed into a 4-entry window whose mean feeds the downstream controller.
// Three consecutive samples with no valid sensor put the block in FALHA.
// Ports:
//   clock_geral  block clock, rising edge
//   reset_n      asynchronous active-low reset
//   bus          umni_aquisicao_if.slave (sensors in, results out)
// Pipeline: sample edge E registers sensors; E+1 computes the sample mean and
// pushes the window; E+2 computes the window mean and pulses media_valida.
module umni_aquisicao #(
    parameter int DIV_AMOSTRA = 4,
    parameter int LIMITE_MAX  = 100
) (
    input logic            clock_geral,
    input logic            reset_n,
    umni_aquisicao_if.slave bus
);
    localparam int             CW      = $clog2(DIV_AMOSTRA);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DIV_AMOSTRA - 1);
    localparam logic [6:0]     LIM     = 7'(LIMITE_MAX);

    typedef enum logic [1:0] {
        VAZIO    = 2'd0,
        ENCHENDO = 2'd1,
        CHEIO    = 2'd2,
        FALHA    = 2'd3
    } estado_t;

    estado_t       estado;
    logic [CW-1:0] cnt;
    logic [6:0]    leitura [4];
    logic [3:0]    ok;
    logic          fase1;
    logic          fase2;
    logic [6:0]    janela [4];
    logic [2:0]    nivel;
    logic [1:0]    rej;
    logic [6:0]    media;
    logic [6:0]    temporal;
    logic          valida;
    logic          cheia;
    logic          falha;

    logic          amostra;
    logic [8:0]    soma_amostra;
    logic [2:0]    n_validos;
    logic [6:0]    media_calc;
    logic [8:0]    soma_janela;
    logic [6:0]    temporal_calc;
    logic [2:0]    nivel_prox;

    assign amostra = (cnt == CNT_MAX);

    // Mean of the readings registered at the last sample event.
    always_comb begin
        soma_amostra = '0;
        n_validos    = '0;
        for (int i = 0; i < 4; i++) begin
            if (ok[i]) begin
                soma_amostra = soma_amostra + {2'b00, leitura[i]};
                n_validos    = n_validos + 3'd1;
            end
        end
        case (n_validos)
            3'd4:    media_calc = soma_amostra[8:2];
            3'd3:    media_calc = 7'(soma_amostra / 9'd3);
            3'd2:    media_calc = soma_amostra[7:1];
            3'd1:    media_calc = soma_amostra[6:0];
            default: media_calc = '0;
        endcase
    end

    // Slots beyond the fill level are always zero, so all four can be summed.
    always_comb begin
        soma_janela = {2'b00, janela[0]} + {2'b00, janela[1]}
                    + {2'b00, janela[2]} + {2'b00, janela[3]};
        case (nivel)
            3'd4:    temporal_calc = soma_janela[8:2];
            3'd3:    temporal_calc = 7'(soma_janela / 9'd3);
            3'd2:    temporal_calc = soma_janela[7:1];
            3'd1:    temporal_calc = soma_janela[6:0];
            default: temporal_calc = '0;
        endcase
        nivel_prox = (nivel == 3'd4) ? 3'd4 : nivel + 3'd1;
    end

    always_ff @(posedge clock_geral or negedge reset_n) begin
        if (!reset_n) begin
            estado   <= VAZIO;
            cnt      <= '0;
            ok       <= '0;
            fase1    <= 1'b0;
            fase2    <= 1'b0;
            nivel    <= '0;
            rej      <= '0;
            media    <= '0;
            temporal <= '0;
            valida   <= 1'b0;
            cheia    <= 1'b0;
            falha    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                leitura[i] <= '0;
                janela[i]  <= '0;
            end
        end else begin
            cnt    <= amostra ? '0 : cnt + 1'b1;
            fase1  <= amostra;
            fase2  <= 1'b0;
            valida <= 1'b0;

            if (amostra) begin
                leitura[0] <= bus.sensor1;
                leitura[1] <= bus.sensor2;
                leitura[2] <= bus.sensor3;
                leitura[3] <= bus.sensor4;
                ok <= {bus.sensor4 <= LIM, bus.sensor3 <= LIM,
                       bus.sensor2 <= LIM, bus.sensor1 <= LIM};
            end

            if (fase2) begin
                temporal <= temporal_calc;
                valida   <= 1'b1;
            end

            if (fase1) begin
                if (|ok) begin
                    media     <= media_calc;
                    janela[0] <= media_calc;
                    janela[1] <= janela[0];
                    janela[2] <= janela[1];
                    janela[3] <= janela[2];
                    nivel     <= nivel_prox;
                    rej       <= '0;
                    fase2     <= 1'b1;
                    cheia     <= (nivel_prox == 3'd4);
                    falha     <= 1'b0;
                    estado    <= (nivel_prox == 3'd4) ? CHEIO : ENCHENDO;
                end else begin
                    // Reject counter saturates so FALHA is held by further rejects.
                    if (rej != 2'd3) begin
                        rej <= rej + 2'd1;
                    end
                    if (rej >= 2'd2) begin
                        estado   <= FALHA;
                        nivel    <= '0;
                        temporal <= '0;
                        cheia    <= 1'b0;
                        falha    <= 1'b1;
                        for (int i = 0; i < 4; i++) begin
                            janela[i] <= '0;
                        end
                    end
                end
            end
        end
    end

    assign bus.umidade_atual_media    = media;
    assign bus.umidade_atual_temporal = temporal;
    assign bus.media_valida           = valida;
    assign bus.sensores_ok            = ok;
    assign bus.janela_cheia           = cheia;
    assign bus.falha_sensor           = falha;
    assign bus.estado                 = estado;
endmodule

// File: tb/tb_umni_aquisicao.sv
// tb_umni_aquisicao
// Directed and randomized sample sequences against a queue-based model of
// the acquisition rules; every sample is checked at E, E+1 and E+2.
module tb_umni_aquisicao;
    localparam int DIV = 4;
    localparam int LIM = 100;

    logic clock_geral = 1'b0;
    logic reset_n     = 1'b0;
    int   checks      = 0;
    int   errors      = 0;
    int   cyc;

    always #5 clock_geral = ~clock_geral;

    umni_aquisicao_if bus ();

    umni_aquisicao #(
        .DIV_AMOSTRA(DIV),
        .LIMITE_MAX (LIM)
    ) dut (
        .clock_geral(clock_geral),
        .reset_n    (reset_n),
        .bus        (bus)
    );

    // Rising edges since reset release; sample events fall on multiples of DIV.
    always @(posedge clock_geral or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    // Reference model state
    int         win_q[$];
    int         rej;
    bit         falha_m;
    int         media_e;
    int         temp_e;
    logic [3:0] ok_e;
    bit         aceito;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        win_q.delete();
        rej     = 0;
        falha_m = 0;
        media_e = 0;
        temp_e  = 0;
        ok_e    = '0;
        aceito  = 0;
    endtask

    task automatic model_sample(input int a, input int b, input int c, input int d);
        int vals[4];
        int sum;
        int n;
        int s;
        vals = '{a, b, c, d};
        sum  = 0;
        n    = 0;
        ok_e = '0;
        for (int i = 0; i < 4; i++) begin
            if (vals[i] <= LIM) begin
                sum     += vals[i];
                n++;
                ok_e[i] = 1'b1;
            end
        end
        if (n > 0) begin
            media_e = sum / n;
            win_q.push_back(media_e);
            if (win_q.size() > 4) void'(win_q.pop_front());
            s = 0;
            foreach (win_q[i]) s += win_q[i];
            temp_e  = s / win_q.size();
            rej     = 0;
            falha_m = 0;
            aceito  = 1;
        end else begin
            aceito = 0;
            rej++;
            if (rej >= 3) begin
                falha_m = 1;
                win_q.delete();
                temp_e = 0;
            end
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_media"},    32'(bus.umidade_atual_media), 0);
        chk({tag, "_temporal"}, 32'(bus.umidade_atual_temporal), 0);
        chk({tag, "_valida"},   32'(bus.media_valida), 0);
        chk({tag, "_ok"},       32'(bus.sensores_ok), 0);
        chk({tag, "_cheia"},    32'(bus.janela_cheia), 0);
        chk({tag, "_falha"},    32'(bus.falha_sensor), 0);
    endtask

    task automatic apply_reset();
        @(negedge clock_geral);
        reset_n = 1'b0;
        #1;
        check_zero("reset");
        model_reset();
        @(negedge clock_geral);
        reset_n = 1'b1;
    endtask

    task automatic do_sample(input int a, input int b, input int c, input int d);
        bit hit;
        hit = 0;
        @(negedge clock_geral);
        bus.sensor1 = 7'(a);
        bus.sensor2 = 7'(b);
        bus.sensor3 = 7'(c);
        bus.sensor4 = 7'(d);
        for (int k = 0; k < 2 * DIV + 2 && !hit; k++) begin
            @(posedge clock_geral);
            #1;
            if (cyc % DIV == 0) hit = 1;
            else chk("pulso_fora", 32'(bus.media_valida), 0);
        end
        chk("amostra_timeout", 32'(hit), 1);
        model_sample(a, b, c, d);
        chk("sensores_ok", 32'(bus.sensores_ok), 32'(ok_e));
        chk("valida_e0", 32'(bus.media_valida), 0);
        @(posedge clock_geral);
        #1;
        chk("media", 32'(bus.umidade_atual_media), media_e);
        chk("valida_e1", 32'(bus.media_valida), 0);
        chk("falha", 32'(bus.falha_sensor), 32'(falha_m));
        chk("cheia_e1", 32'(bus.janela_cheia), 32'(win_q.size() == 4));
        @(posedge clock_geral);
        #1;
        chk("temporal", 32'(bus.umidade_atual_temporal), temp_e);
        chk("valida_e2", 32'(bus.media_valida), 32'(aceito));
        chk("cheia_e2", 32'(bus.janela_cheia), 32'(win_q.size() == 4));
    endtask

    initial begin
        int r;
        bit hit;
        model_reset();
        bus.sensor1 = '0;
        bus.sensor2 = '0;
        bus.sensor3 = '0;
        bus.sensor4 = '0;
        #12;
        check_zero("reset_inicial");
        @(negedge clock_geral);
        reset_n = 1'b1;

        // Constant valid sensors: media and temporal 66, window fills on 4th
        repeat (5) do_sample(60, 64, 68, 72);

        // One out-of-range sensor, three-way mean
        do_sample(120, 30, 30, 33);

        // Window averaging sequence 40,40,40,80,80
        apply_reset();
        repeat (3) do_sample(40, 40, 40, 40);
        repeat (2) do_sample(80, 80, 80, 80);

        // Three rejects into FALHA, then recovery
        repeat (3) do_sample(127, 127, 127, 127);
        do_sample(50, 50, 50, 50);

        // Two rejects then an accept must not reach FALHA
        do_sample(101, 110, 127, 105);
        do_sample(101, 110, 127, 105);
        do_sample(0, 101, 101, 100);

        // Randomized traffic, including bursts of all-invalid samples
        repeat (60) begin
            r = $urandom_range(0, 9);
            if (r < 3)
                do_sample($urandom_range(101, 127), $urandom_range(101, 127),
                          $urandom_range(101, 127), $urandom_range(101, 127));
            else
                do_sample($urandom_range(0, 127), $urandom_range(0, 127),
                          $urandom_range(0, 127), $urandom_range(0, 127));
        end

        // Reset between a sample edge and its pulse
        @(negedge clock_geral);
        bus.sensor1 = 7'd10;
        bus.sensor2 = 7'd20;
        bus.sensor3 = 7'd30;
        bus.sensor4 = 7'd40;
        hit = 0;
        for (int k = 0; k < 2 * DIV + 2 && !hit; k++) begin
            @(posedge clock_geral);
            #1;
            if (cyc % DIV == 0) hit = 1;
        end
        chk("meio_timeout", 32'(hit), 1);
        #1;
        reset_n = 1'b0;
        #1;
        check_zero("reset_meio");
        model_reset();
        #1;
        reset_n = 1'b1;
        do_sample(10, 20, 30, 40);
        do_sample(10, 20, 30, 40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
